// File: rtl/lfsr_cmp_pkg.sv
// Shared definitions for the LFSR compare engine: FSM state encoding and default sizing.
package lfsr_cmp_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_SEARCH  = 2'd1;
  localparam state_t ST_FOUND   = 2'd2;
  localparam state_t ST_TIMEOUT = 2'd3;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_MAX_STEPS = 65535;
  localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/lfsr_cmp_counter.sv
// Step counter for the compare engine: synchronous clear, guarded increment, terminal-count flag.
module lfsr_cmp_counter
  import lfsr_cmp_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int MAX_STEPS = DEF_MAX_STEPS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_STEPS - 1);

  assign tc = (cnt == LAST_IDX);

  // Holding at terminal count keeps the counter from ever wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !tc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lfsr_compare_engine.sv
// Search engine that steps an external LFSR until its output matches a captured key or a step budget runs out.
// Optional don't-care masking of the compare is enabled by defining LFSR_CMP_MASK_EN.
module lfsr_compare_engine
  import lfsr_cmp_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_STEPS = DEF_MAX_STEPS,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             LFSR_Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Clear,
  input  logic [WIDTH-1:0] Key,
`ifdef LFSR_CMP_MASK_EN
  input  logic [WIDTH-1:0] Key_Mask,
`endif
  input  logic [WIDTH-1:0] LFSR_OUT,
  output logic             LFSR_Enable,
  output logic             Compare_Found,
  output logic             Done,
  output logic             Timeout,
  output logic [CNT_W-1:0] Match_Index
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_STEPS - 1);

  state_t           state;
  logic [WIDTH-1:0] key_q;
  logic [CNT_W-1:0] step_cnt;
  logic             step_tc;
  logic             hit;
  logic             in_search;
  logic             start_acc;

`ifdef LFSR_CMP_MASK_EN
  logic [WIDTH-1:0] mask_q;
  assign hit = ((LFSR_OUT ^ key_q) & ~mask_q) == '0;
`else
  assign hit = (LFSR_OUT == key_q);
`endif

  assign in_search = (state == ST_SEARCH);
  assign start_acc = Start && !Clear && !in_search;

  // Combinational so the generator never steps past the matching word.
  assign LFSR_Enable = in_search && !hit;

  lfsr_cmp_counter #(
    .CNT_W     (CNT_W),
    .MAX_STEPS (MAX_STEPS)
  ) u_counter (
    .clk   (LFSR_Clock),
    .rst_n (Reset),
    .clr   (start_acc),
    .inc   (in_search && !hit && !Clear),
    .cnt   (step_cnt),
    .tc    (step_tc)
  );

  always_ff @(posedge LFSR_Clock or negedge Reset) begin
    if (!Reset) begin
      key_q  <= '0;
`ifdef LFSR_CMP_MASK_EN
      mask_q <= '0;
`endif
    end else if (start_acc) begin
      key_q  <= Key;
`ifdef LFSR_CMP_MASK_EN
      mask_q <= Key_Mask;
`endif
    end
  end

  // Clear beats Start; Match_Index is only written on search completion.
  always_ff @(posedge LFSR_Clock or negedge Reset) begin
    if (!Reset) begin
      state         <= ST_IDLE;
      Done          <= 1'b0;
      Compare_Found <= 1'b0;
      Timeout       <= 1'b0;
      Match_Index   <= '0;
    end else if (Clear) begin
      state         <= ST_IDLE;
      Done          <= 1'b0;
      Compare_Found <= 1'b0;
      Timeout       <= 1'b0;
    end else begin
      case (state)
        ST_SEARCH: begin
          if (hit) begin
            state         <= ST_FOUND;
            Match_Index   <= step_cnt;
            Done          <= 1'b1;
            Compare_Found <= 1'b1;
          end else if (step_tc) begin
            state       <= ST_TIMEOUT;
            Match_Index <= LAST_IDX;
            Done        <= 1'b1;
            Timeout     <= 1'b1;
          end
        end
        default: begin
          if (Start) begin
            state         <= ST_SEARCH;
            Done          <= 1'b0;
            Compare_Found <= 1'b0;
            Timeout       <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
